bin_conv_seq: RTL

BIN_CONV_SEQ -- requirements
Module: bin_conv_seq

---
 rtl/bin_conv_pkg.sv | 26 ++
 rtl/bcd_digit_adj.sv | 10 +
 rtl/bin_conv_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/bin_conv_pkg.sv
// Shared types, mode encodings and width helpers for the serial binary
// converter (two's-complement negate / double-dabble BCD).
package bin_conv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_2SC = 1'b0;
   localparam logic MODE_BCD = 1'b1;

   // Output width: wide enough for the negate result plus carry, or for all BCD digits.
   function automatic int calc_ow(input int width, input int ndig);
      return ((width + 1) > (4 * ndig)) ? (width + 1) : (4 * ndig);
   endfunction

   function automatic longint pow10(input int n);
      longint r;
      r = 64'sd1;
      for (int i = 0; i < n; i++) r = r * 64'sd10;
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next digit.
module bcd_digit_adj (
   input  logic [3:0] digit,
   output logic [3:0] adj
);

   assign adj = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin_conv_seq.sv
// Bit-serial converter: mode 0 negates the operand LSB-first through a
// half-adder chain, mode 1 converts it to packed BCD MSB-first (double dabble).
module bin_conv_seq
   import bin_conv_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int NDIG  = 3,
   localparam int OW    = calc_ow(WIDTH, NDIG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OW-1:0]    out_data,
   output logic             out_mode,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int BW = 4 * NDIG;

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("bin_conv_seq: WIDTH must be in 2..32");
   end
   if (pow10(NDIG) <= ((longint'(1) << WIDTH) - longint'(1))) begin : g_bad_ndig
      $error("bin_conv_seq: NDIG too small to hold 2^WIDTH-1 in BCD");
   end

   state_t           state, state_next;
   logic [WIDTH-1:0] opnd;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             last_bit;
   logic [BW-1:0]    bcd_adj;
   logic [BW+WIDTH-1:0] dd_shift;

   // Digit correction always looks at the BCD field of the result register;
   // its output is only consumed in BCD mode.
   for (genvar g = 0; g < NDIG; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit (out_data[4*g +: 4]),
         .adj   (bcd_adj[4*g +: 4])
      );
   end

   assign dd_shift  = {bcd_adj, opnd} << 1;
   assign last_bit  = (cnt == CW'(WIDTH - 1));

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order within the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: next-state defaults to the current state before the case, so no
   // path through the block leaves state_next unassigned (no latch).
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (in_valid)  state_next = CONV;
         CONV:    if (last_bit)  state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opnd     <= '0;
         out_data <= '0;
         out_mode <= 1'b0;
         cnt      <= '0;
         carry    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  opnd     <= in_data;
                  out_mode <= in_mode;
                  out_data <= '0;
                  cnt      <= '0;
                  carry    <= 1'b1;
               end
            end
            CONV: begin
               cnt <= cnt + 1'b1;
               if (out_mode == MODE_2SC) begin
                  // ~a + 1 one bit at a time; the chain's final carry lands in bit WIDTH.
                  out_data[cnt] <= ~opnd[0] ^ carry;
                  carry         <= ~opnd[0] & carry;
                  opnd          <= opnd >> 1;
                  if (last_bit) out_data[WIDTH] <= ~opnd[0] & carry;
               end else begin
                  out_data[BW-1:0] <= dd_shift[BW+WIDTH-1:WIDTH];
                  opnd             <= dd_shift[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
